// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_W    = 3'd3,
        ST_B    = 3'd4
    } tx_state_e;

    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [2:0]  AXI_PROT      = 3'b000;
    localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0008;
    localparam logic [31:0] DEF_TXD_ADDR  = 32'h0000_0000;
    localparam int          POLL_W        = 10;

    // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is treated as a failure.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module uart_tx_sched_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    // Scan from the pointer upward; the first hit wins.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters over AXI4-lite.
//
// state | meaning
// IDLE  | waiting for the granted (or newly arbitrated) requester's byte
// AR    | status read address issued
// R     | waiting for status data; ready -> write, not ready -> poll again
// W     | data write address/data issued, each dropped after its handshake
// B     | waiting for write response
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int          NUM_REQ        = 2,
    parameter logic [31:0] STAT_ADDR      = DEF_STAT_ADDR,
    parameter logic [31:0] TXD_ADDR       = DEF_TXD_ADDR,
    parameter int          TX_RDY_BIT     = 0,
    parameter int          POLL_MAX       = 1023,
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [8*NUM_REQ-1:0]        req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        AWVALID,
    input  logic                        AWREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]                  AWPROT,
    output logic                        WVALID,
    input  logic                        WREADY,
    output logic [AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                        BVALID,
    output logic                        BREADY,
    input  logic [1:0]                  BRESP,
    output logic                        ARVALID,
    input  logic                        ARREADY,
    output logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]                  ARPROT,
    input  logic                        RVALID,
    output logic                        RREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                  RRESP,
    output logic                        busy,
    output logic                        err
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    tx_state_e           state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    grant_idx_q;
    logic                grant_held_q;
    logic [7:0]          byte_q;
    logic                last_q;
    logic [POLL_W-1:0]   poll_left_q;
    logic                aw_done_q, w_done_q;

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic [PTR_W-1:0]    sel_idx;
    logic                sel_valid, sel_last;
    logic [7:0]          sel_byte;
    logic                accept;
    logic                r_fire, rd_err, rd_rdy, rd_busy, poll_tc, drop;
    logic                aw_fire, w_fire, wr_both, b_fire, byte_end;
    logic [PTR_W-1:0]    ptr_next;
    logic                unused_rdata;

    assign unused_rdata = ^RDATA;

    uart_tx_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // A held grant pins the requester; otherwise the arbiter chooses.
    always_comb begin
        sel_idx   = grant_held_q ? grant_idx_q : arb_idx;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_byte  = req_data[8*i +: 8];
            end
        end
    end

    assign accept   = (state_q == ST_IDLE) && sel_valid;
    assign r_fire   = (state_q == ST_R) && RVALID;
    assign rd_err   = r_fire && resp_is_err(RRESP);
    assign rd_rdy   = r_fire && !rd_err && RDATA[TX_RDY_BIT];
    assign rd_busy  = r_fire && !rd_err && !RDATA[TX_RDY_BIT];
    assign poll_tc  = (poll_left_q == POLL_W'(1));
    assign drop     = rd_err || (rd_busy && poll_tc);
    assign aw_fire  = AWVALID && AWREADY;
    assign w_fire   = WVALID && WREADY;
    assign wr_both  = (state_q == ST_W) && (aw_done_q || aw_fire) && (w_done_q || w_fire);
    assign b_fire   = (state_q == ST_B) && BVALID;
    assign byte_end = b_fire || drop;
    assign ptr_next = (grant_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_q + PTR_W'(1);

    // State register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)  state_d = ST_AR;
            ST_AR:   if (ARREADY) state_d = ST_R;
            ST_R: begin
                if (drop)         state_d = ST_IDLE;
                else if (rd_rdy)  state_d = ST_W;
                else if (rd_busy) state_d = ST_AR;
            end
            ST_W:    if (wr_both) state_d = ST_B;
            ST_B:    if (b_fire)  state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Bus and handshake outputs; req_ready is held low while reset is asserted.
    always_comb begin
        ARVALID   = (state_q == ST_AR);
        RREADY    = (state_q == ST_R);
        AWVALID   = (state_q == ST_W) && !aw_done_q;
        WVALID    = (state_q == ST_W) && !w_done_q;
        BREADY    = (state_q == ST_B);
        err       = drop || (b_fire && resp_is_err(BRESP));
        busy      = (state_q != ST_IDLE) || grant_held_q;
        req_ready = '0;
        if (accept && ARESETn) begin
            req_ready[sel_idx] = 1'b1;
        end
    end

    assign ARADDR = AXI_ADDR_WIDTH'(STAT_ADDR);
    assign AWADDR = AXI_ADDR_WIDTH'(TXD_ADDR);
    assign ARPROT = AXI_PROT;
    assign AWPROT = AXI_PROT;
    assign WDATA  = AXI_DATA_WIDTH'(byte_q);
    assign WSTRB  = STRB_W'(1);

    // Byte latch, poll budget and independent AW/W completion flags.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            byte_q      <= '0;
            last_q      <= 1'b0;
            poll_left_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            if (accept) begin
                byte_q      <= sel_byte;
                last_q      <= sel_last;
                poll_left_q <= POLL_W'(POLL_MAX);
            end else if (rd_busy && !poll_tc) begin
                poll_left_q <= poll_left_q - POLL_W'(1);
            end
            aw_done_q <= (state_q == ST_W) && !wr_both && (aw_done_q || aw_fire);
            w_done_q  <= (state_q == ST_W) && !wr_both && (w_done_q || w_fire);
        end
    end

    // Grant is taken on accept and only released when the message's last byte ends.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            grant_held_q <= 1'b0;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            if (accept) begin
                grant_held_q <= 1'b1;
                grant_idx_q  <= sel_idx;
            end else if (byte_end && last_q) begin
                grant_held_q <= 1'b0;
                rr_ptr_q     <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural AXI4-lite UART slave.
module tb_uart_tx_sched;

    localparam int          NR   = 2;
    localparam int          TMO  = 6000;
    localparam logic [31:0] STAT = 32'h0000_0008;
    localparam logic [31:0] TXD  = 32'h0000_0000;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR-1:0] req_last = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] req_ready;
    logic          AWVALID, AWREADY = 1'b0;
    logic [31:0]   AWADDR;
    logic [2:0]    AWPROT;
    logic          WVALID, WREADY = 1'b0;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          BVALID = 1'b0, BREADY;
    logic [1:0]    BRESP = 2'b00;
    logic          ARVALID, ARREADY = 1'b1;
    logic [31:0]   ARADDR;
    logic [2:0]    ARPROT;
    logic          RVALID = 1'b0, RREADY;
    logic [31:0]   RDATA = '0;
    logic [1:0]    RRESP = 2'b00;
    logic          busy, err;

    int n_cmp = 0, n_fail = 0;
    logic [7:0] exp_q[$];
    logic [2:0] stat_q[$];
    bit         stuck0 = 0, b_hold = 0;
    int         aw_dly = 0, w_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;
    int         ar_cnt = 0, wr_cnt = 0, err_cnt = 0, aw_rise = 0, w_rise = 0, b_cnt = 0;

    always #5 ACLK = ~ACLK;

    uart_tx_sched #(.NUM_REQ(NR)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int r, input logic [7:0] b, input logic last);
        int n;
        @(posedge ACLK); #1;
        req_valid[r] = 1'b1;
        req_data[8*r +: 8] = b;
        req_last[r] = last;
        n = 0;
        do begin @(negedge ACLK); n++; end while (!req_ready[r] && n < TMO);
        chk("req_ready_tmo", 32'(req_ready[r]), 32'd1);
        @(posedge ACLK); #1;
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin @(negedge ACLK); n++; end while (busy && n < TMO);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge ACLK);
    endtask

    // Behavioural UART slave: handshakes sampled at negedge, responses driven after posedge.
    initial begin
        bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got, prev_aw, prev_w;
        int aw_wait, w_wait;
        logic [2:0] rsp;
        aw_got = 0; w_got = 0; prev_aw = 0; prev_w = 0; aw_wait = 0; w_wait = 0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY;
            r_hs  = RVALID && RREADY;
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            b_hs  = BVALID && BREADY;
            if (err) err_cnt++;
            if (AWVALID && !prev_aw) aw_rise++;
            if (WVALID && !prev_w) w_rise++;
            prev_aw = AWVALID;
            prev_w  = WVALID;
            if (ar_hs) begin
                ar_cnt++;
                chk("araddr", ARADDR, STAT);
                chk("arprot", 32'(ARPROT), 32'd0);
            end
            if (aw_hs) begin
                aw_got = 1;
                chk("awaddr", AWADDR, TXD);
                chk("awprot", 32'(AWPROT), 32'd0);
            end
            if (w_hs) begin
                wr_cnt++;
                w_got = 1;
                chk("wstrb", 32'(WSTRB), 32'd1);
                chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("wdata", WDATA, 32'(exp_q.pop_front()));
            end
            if (b_hs) b_cnt++;
            @(posedge ACLK); #1;
            if (!ARESETn) begin
                RVALID = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
                aw_got = 0; w_got = 0; aw_wait = 0; w_wait = 0;
            end else begin
                if (r_hs) RVALID = 0;
                if (ar_hs) begin
                    rsp = (stat_q.size() > 0) ? stat_q.pop_front() : {2'b00, !stuck0};
                    RVALID = 1;
                    RRESP  = rsp[2:1];
                    RDATA  = 32'hFFFF_FFFE | {31'b0, rsp[0]};
                end
                if (AWVALID) begin AWREADY = (aw_wait >= aw_dly); aw_wait++; end
                else begin AWREADY = 0; aw_wait = 0; end
                if (WVALID) begin WREADY = (w_wait >= w_dly); w_wait++; end
                else begin WREADY = 0; w_wait = 0; end
                if (b_hs) BVALID = 0;
                else if (aw_got && w_got && !BVALID && !b_hold) begin
                    BVALID = 1; BRESP = bresp_cfg; aw_got = 0; w_got = 0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, w0, lat, n;
        // Reset: every output quiet even with a requester waiting.
        req_valid = 2'b01;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_outputs", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, err, req_ready}), 32'd0);
        req_valid = '0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);

        // 1: single byte, zero-wait slave, latency to AWVALID.
        ar_cnt = 0; wr_cnt = 0; e0 = err_cnt;
        exp_q.push_back(8'h41);
        fork
            send(0, 8'h41, 1'b1);
            begin
                @(posedge ACLK); #1;
                lat = 0;
                do begin @(negedge ACLK); lat++; end while (!AWVALID && lat < 50);
            end
        join
        wait_idle("t1");
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_ar_cnt", 32'(ar_cnt), 32'd1);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("t1_err", 32'(err_cnt - e0), 32'd0);

        // 2: status not ready for three reads.
        ar_cnt = 0; wr_cnt = 0;
        repeat (3) stat_q.push_back(3'b000);
        exp_q.push_back(8'h52);
        send(1, 8'h52, 1'b1);
        wait_idle("t2");
        chk("t2_ar_cnt", 32'(ar_cnt), 32'd4);
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd1);

        // 3a: grant held across a two-byte message, then rotation.
        exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
        fork
            begin send(0, "A", 1'b0); send(0, "B", 1'b1); end
            send(1, "C", 1'b1);
        join
        wait_idle("t3a");
        // 3b: after req0 finishes, req1 wins a simultaneous request.
        exp_q.push_back("D"); exp_q.push_back("F"); exp_q.push_back("E");
        send(0, "D", 1'b1);
        wait_idle("t3b0");
        fork
            send(0, "E", 1'b1);
            send(1, "F", 1'b1);
        join
        wait_idle("t3b");
        chk("t3_sb_drained", 32'(exp_q.size()), 32'd0);

        // 4a: read SLVERR drops the byte; next byte proceeds.
        e0 = err_cnt; wr_cnt = 0;
        stat_q.push_back(3'b100);
        send(0, 8'h11, 1'b1);
        wait_idle("t4a");
        chk("t4a_err", 32'(err_cnt - e0), 32'd1);
        chk("t4a_wr_cnt", 32'(wr_cnt), 32'd0);
        exp_q.push_back(8'h22);
        send(0, 8'h22, 1'b1);
        wait_idle("t4a2");
        chk("t4a2_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("t4a2_err", 32'(err_cnt - e0), 32'd1);

        // 4c: write response error.
        e0 = err_cnt; wr_cnt = 0; bresp_cfg = 2'b10;
        exp_q.push_back(8'h44);
        send(0, 8'h44, 1'b1);
        wait_idle("t4c");
        bresp_cfg = 2'b00;
        chk("t4c_err", 32'(err_cnt - e0), 32'd1);
        chk("t4c_wr_cnt", 32'(wr_cnt), 32'd1);

        // 4b: status stuck not-ready -> timeout after POLL_MAX reads.
        e0 = err_cnt; wr_cnt = 0; ar_cnt = 0; stuck0 = 1;
        send(0, 8'h33, 1'b1);
        wait_idle("t4b");
        stuck0 = 0;
        chk("t4b_ar_cnt", 32'(ar_cnt), 32'd1023);
        chk("t4b_err", 32'(err_cnt - e0), 32'd1);
        chk("t4b_wr_cnt", 32'(wr_cnt), 32'd0);

        // 5: AW/W handshake skew in both directions.
        aw_rise = 0; w_rise = 0; b_cnt = 0; aw_dly = 0; w_dly = 3;
        exp_q.push_back(8'h55);
        send(0, 8'h55, 1'b1);
        wait_idle("t5a");
        chk("t5a_aw_rise", 32'(aw_rise), 32'd1);
        chk("t5a_w_rise", 32'(w_rise), 32'd1);
        chk("t5a_b_cnt", 32'(b_cnt), 32'd1);
        aw_rise = 0; w_rise = 0; b_cnt = 0; aw_dly = 3; w_dly = 0;
        exp_q.push_back(8'h56);
        send(0, 8'h56, 1'b1);
        wait_idle("t5b");
        aw_dly = 0;
        chk("t5b_aw_rise", 32'(aw_rise), 32'd1);
        chk("t5b_w_rise", 32'(w_rise), 32'd1);
        chk("t5b_b_cnt", 32'(b_cnt), 32'd1);

        // 6: reset while waiting on B, then pointer back at requester 0.
        b_hold = 1;
        exp_q.push_back(8'h66);
        send(0, 8'h66, 1'b1);
        n = 0;
        do begin @(negedge ACLK); n++; end while (!BREADY && n < TMO);
        chk("t6_bready_reached", 32'(BREADY), 32'd1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("t6_rst_outputs", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY, busy, err, req_ready}), 32'd0);
        b_hold = 0;
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        chk("t6_idle_after", 32'(busy), 32'd0);
        exp_q.push_back(8'h70); exp_q.push_back(8'h71);
        fork
            send(0, 8'h70, 1'b1);
            send(1, 8'h71, 1'b1);
        join
        wait_idle("t6");
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
